// File: rtl/fft_ram_arbiter.sv
// fft_ram_arbiter: round-robin, burst-locked sharing of one FFT RAM read port with latency-aligned read tagging.
// Optional burst watchdog (adds wd_trip output) enabled by FFTARB_WATCHDOG_EN.
module fft_ram_arbiter #(
  parameter int NREQ = 2,
  parameter int AW = 10,
  parameter int DW = 28,
  parameter int RD_LAT = 2,
  parameter int WD_MAX = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0] grant,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_q,
  output logic [NREQ-1:0] rvalid,
  output logic [DW-1:0] rdata,
  output logic busy
`ifdef FFTARB_WATCHDOG_EN
  ,
  output logic wd_trip
`endif
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, own, own_nxt, sel;
  logic [NREQ-1:0] grant_nxt;
  logic [NREQ-1:0] tags [RD_LAT];
  logic [AW-1:0] addr_q;
  logic found, issue, done, wd_hit, any_tag;

  if (NREQ < 2 || NREQ > 8 || RD_LAT < 1 || RD_LAT > 4 || WD_MAX < 1) begin : g_bad
    $error("fft_ram_arbiter: parameter out of range");
  end

  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        sel = IW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign issue = (state == BUSY) && req[own];
  assign done = (state == BUSY) && (!req[own] || last[own] || wd_hit);
  assign ram_addr = issue ? addr[own*AW +: AW] : addr_q;
  assign rvalid = tags[RD_LAT-1];
  assign rdata = ram_q;
  assign busy = (state == BUSY) || any_tag;

  always_comb begin
    state_nxt = state == IDLE ? (found ? BUSY : IDLE) : (done ? IDLE : BUSY);
    grant_nxt = state == IDLE ? (found ? NREQ'(1) << sel : '0) : (done ? '0 : grant);
    own_nxt = (state == IDLE && found) ? sel : own;
    ptr_nxt = done ? IW'((int'(own) + 1) % NREQ) : ptr;
    any_tag = 1'b0;
    for (int i = 0; i < RD_LAT; i++) any_tag = any_tag | (|tags[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      own <= '0;
      ptr <= '0;
      addr_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tags[i] <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      own <= own_nxt;
      ptr <= ptr_nxt;
      addr_q <= ram_addr;
      tags[0] <= issue ? grant : '0;
      for (int i = 1; i < RD_LAT; i++) tags[i] <= tags[i-1];
    end
  end

`ifdef FFTARB_WATCHDOG_EN
  localparam int CW = $clog2(WD_MAX + 1);
  logic [CW-1:0] cnt;
  // Only a read that is not itself the last one can trip the limit.
  assign wd_hit = issue && !last[own] && cnt == CW'(WD_MAX - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      wd_trip <= 1'b0;
    end else begin
      cnt <= state == IDLE ? '0 : cnt + CW'(issue);
      wd_trip <= wd_hit;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif
endmodule
